// File: rtl/mp_pkg.sv
// rtl/mp_pkg.sv - shared encodings and defaults for the multi-precision add/sub engine
package mp_pkg;

  localparam int DEF_LIMB_WIDTH = 257;
  localparam int DEF_NUM_LIMBS  = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MADD = 2'b10,
    OP_MSUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mp_addsub_mod_if.sv
// rtl/mp_addsub_mod_if.sv - request/result bundle between operand registers and the add/sub engine
interface mp_addsub_mod_if #(
  parameter int LIMB_WIDTH = mp_pkg::DEF_LIMB_WIDTH,
  parameter int NUM_LIMBS  = mp_pkg::DEF_NUM_LIMBS
);
  localparam int DATA_WIDTH = LIMB_WIDTH * NUM_LIMBS - 1;

  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [DATA_WIDTH-1:0] in_m;
  logic [DATA_WIDTH:0]   result;
  logic                  flag;
  logic                  busy;
  logic                  done;

  modport master (
    output start, op, in_a, in_b, in_m,
    input  result, flag, busy, done
  );

  modport slave (
    input  start, op, in_a, in_b, in_m,
    output result, flag, busy, done
  );
endinterface

// File: rtl/mp_limb_addsub.sv
// rtl/mp_limb_addsub.sv - one-limb adder with optional b inversion, shared by both passes
module mp_limb_addsub #(
  parameter int LIMB_WIDTH = mp_pkg::DEF_LIMB_WIDTH
) (
  input  logic [LIMB_WIDTH-1:0] a,
  input  logic [LIMB_WIDTH-1:0] b,
  input  logic                  invert_b,
  input  logic                  cin,
  output logic [LIMB_WIDTH-1:0] sum,
  output logic                  cout
);
  logic [LIMB_WIDTH-1:0] b_eff;
  logic [LIMB_WIDTH:0]   total;

  assign b_eff = invert_b ? ~b : b;
  assign total = {1'b0, a} + {1'b0, b_eff} + {{LIMB_WIDTH{1'b0}}, cin};
  assign sum   = total[LIMB_WIDTH-1:0];
  assign cout  = total[LIMB_WIDTH];
endmodule

// File: rtl/mp_addsub_mod.sv
// rtl/mp_addsub_mod.sv - limb-serial add/sub with optional modular correction pass
module mp_addsub_mod
  import mp_pkg::*;
#(
  parameter int LIMB_WIDTH = DEF_LIMB_WIDTH,
  parameter int NUM_LIMBS  = DEF_NUM_LIMBS
) (
  input  logic            clk,
  input  logic            reset,
  mp_addsub_mod_if.slave  bus
);
  localparam int W  = LIMB_WIDTH * NUM_LIMBS;
  localparam int L  = LIMB_WIDTH;
  localparam int CW = $clog2(NUM_LIMBS + 1);
  localparam logic [CW-1:0] LAST_LIMB = CW'(NUM_LIMBS - 1);
  localparam logic [CW-1:0] WRITEBACK = CW'(NUM_LIMBS);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, m_q, m_d;
  logic [W-1:0]    s_q, s_d, t_q, t_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            borrow_q, borrow_d;
  logic            flag_q, flag_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            in_pass2;
  logic [L-1:0]    add_a, add_b, add_sum;
  logic            add_inv, add_cout;
  logic            accept, sel;

  // PASS2 reuses the adder on the low limb of s and m; PASS1 on a and b.
  assign in_pass2 = (state_q == PASS2);
  assign add_a    = in_pass2 ? s_q[L-1:0] : a_q[L-1:0];
  assign add_b    = in_pass2 ? m_q[L-1:0] : b_q[L-1:0];
  assign add_inv  = in_pass2 ? (op_q == OP_MADD) : op_q[0];

  mp_limb_addsub #(.LIMB_WIDTH(L)) u_limb (
    .a        (add_a),
    .b        (add_b),
    .invert_b (add_inv),
    .cin      (carry_q),
    .sum      (add_sum),
    .cout     (add_cout)
  );

  assign accept = bus.start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    s_d      = s_q;
    t_d      = t_q;
    result_d = result_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    flag_d   = flag_q;
    sel      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d    = op_e'(bus.op);
          a_d     = {1'b0, bus.in_a};
          b_d     = {1'b0, bus.in_b};
          m_d     = {1'b0, bus.in_m};
          cnt_d   = '0;
          carry_d = bus.op[0];
          state_d = PASS1;
        end
      end
      PASS1: begin
        if (cnt_q != WRITEBACK) begin
          a_d     = {{L{1'b0}}, a_q[W-1:L]};
          b_d     = {{L{1'b0}}, b_q[W-1:L]};
          s_d     = {add_sum, s_q[W-1:L]};
          carry_d = add_cout;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_LIMB && op_q[1]) begin
            borrow_d = ~add_cout;
            carry_d  = (op_q == OP_MADD);
            cnt_d    = '0;
            state_d  = PASS2;
          end
        end else begin
          result_d = s_q;
          flag_d   = op_q[0] ? ~carry_q : s_q[W-1];
          state_d  = DONE;
        end
      end
      PASS2: begin
        if (cnt_q != WRITEBACK) begin
          // s rotates so it is intact again once all limbs have passed
          m_d     = {{L{1'b0}}, m_q[W-1:L]};
          s_d     = {s_q[L-1:0], s_q[W-1:L]};
          t_d     = {add_sum, t_q[W-1:L]};
          carry_d = add_cout;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          sel      = (op_q == OP_MADD) ? carry_q : borrow_q;
          result_d = sel ? t_q : s_q;
          flag_d   = sel;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      flag_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      s_q      <= s_d;
      t_q      <= t_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      flag_q   <= flag_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.flag   = flag_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_mp_addsub_mod.sv
// tb/tb_mp_addsub_mod.sv - directed and randomized checks of mp_addsub_mod against an arithmetic model
module tb_mp_addsub_mod;
  localparam int LW = 257;
  localparam int NL = 4;
  localparam int DW = LW * NL - 1;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mp_addsub_mod_if #(.LIMB_WIDTH(LW), .NUM_LIMBS(NL)) bus ();

  mp_addsub_mod #(.LIMB_WIDTH(LW), .NUM_LIMBS(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW+1:0] obs, input logic [DW+1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed(low128)=%0h expected(low128)=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [1055:0] v;
    for (int i = 0; i < 33; i++) v[i*32 +: 32] = $urandom;
    return v[DW-1:0];
  endfunction

  // Returns {flag, result} computed directly from the arithmetic definition of each op.
  function automatic logic [DW+1:0] model(input logic [1:0] o, input logic [DW:0] a,
                                          input logic [DW:0] b, input logic [DW:0] m);
    logic [DW:0] r;
    logic        f;
    case (o)
      2'b00: begin r = a + b; f = r[DW]; end
      2'b01: begin r = a - b; f = (a < b); end
      2'b10: begin
        r = a + b;
        f = (r >= m);
        if (f) r = r - m;
      end
      default: begin
        f = (a < b);
        r = f ? (a - b + m) : (a - b);
      end
    endcase
    return {f, r};
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] m, input logic [DW:0] exp_r, input logic exp_f,
                        input bit intrude, input string tag);
    int cyc;
    bit seen;
    int lat;
    lat = o[1] ? 2 * NL + 1 : NL + 1;
    bus.start = 1'b1;
    bus.op    = o;
    bus.in_a  = a;
    bus.in_b  = b;
    bus.in_m  = m;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.in_a  = rnd();
    bus.in_b  = rnd();
    bus.in_m  = rnd();
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (intrude && cyc == 2) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.in_a  = rnd();
        bus.in_b  = rnd();
      end
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_latency"}, (DW+2)'(cyc), (DW+2)'(lat));
    chk({tag, "_result"}, (DW+2)'(bus.result), (DW+2)'(exp_r));
    chk({tag, "_flag"}, (DW+2)'(bus.flag), (DW+2)'(exp_f));
    chk({tag, "_busy"}, (DW+2)'(bus.busy), (DW+2)'(1'b1));
  endtask

  initial begin
    logic [DW-1:0]  x, y, m;
    logic [DW:0]    e;
    logic [DW+1:0]  fr;
    logic [1:0]     o;
    int             dones;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.in_a  = '0;
    bus.in_b  = '0;
    bus.in_m  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", (DW+2)'(bus.result), '0);
    chk("rst_flag", (DW+2)'(bus.flag), '0);
    chk("rst_busy", (DW+2)'(bus.busy), '0);
    chk("rst_done", (DW+2)'(bus.done), '0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, DW'(1000), DW'(2000), '0, (DW+1)'(3000), 1'b0, 1'b0, "add_small");
    run_op(2'b01, DW'(3000), DW'(1500), '0, (DW+1)'(1500), 1'b0, 1'b0, "sub_small");
    run_op(2'b01, DW'(0), DW'(1), '0, '1, 1'b1, 1'b0, "sub_neg");

    x = '0;
    x[LW-1:0] = '1;
    e = '0;
    e[LW] = 1'b1;
    run_op(2'b00, x, DW'(1), '0, e, 1'b0, 1'b0, "add_limbcarry");

    x = '1;
    e = '1;
    e[0] = 1'b0;
    run_op(2'b00, x, x, '0, e, 1'b1, 1'b0, "add_full");

    run_op(2'b10, DW'(60), DW'(50), DW'(97), (DW+1)'(13), 1'b1, 1'b0, "madd_wrap");
    run_op(2'b10, DW'(10), DW'(20), DW'(97), (DW+1)'(30), 1'b0, 1'b0, "madd_nowrap");
    run_op(2'b11, DW'(10), DW'(20), DW'(97), (DW+1)'(87), 1'b1, 1'b0, "msub_wrap");
    run_op(2'b11, DW'(20), DW'(10), DW'(97), (DW+1)'(10), 1'b0, 1'b0, "msub_nowrap");

    run_op(2'b10, DW'(96), DW'(5), DW'(97), (DW+1)'(4), 1'b1, 1'b1, "ignored_start");

    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.in_a  = DW'(5);
    bus.in_b  = DW'(9);
    bus.in_m  = DW'(97);
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_result", (DW+2)'(bus.result), '0);
    chk("midrst_flag", (DW+2)'(bus.flag), '0);
    chk("midrst_busy", (DW+2)'(bus.busy), '0);
    chk("midrst_done", (DW+2)'(bus.done), '0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("midrst_no_done", (DW+2)'(dones), '0);

    run_op(2'b10, DW'(80), DW'(30), DW'(97), (DW+1)'(13), 1'b1, 1'b0, "after_rst");

    for (int n = 0; n < 24; n++) begin
      o = 2'($urandom);
      if (n % 3 == 0) m = DW'($urandom | 32'd1);
      else begin
        m = rnd();
        if (m == '0) m = DW'(1);
      end
      if (o[1]) begin
        x = rnd() % m;
        y = rnd() % m;
      end else begin
        x = rnd();
        y = (n % 4 == 0) ? x : rnd();
      end
      fr = model(o, {1'b0, x}, {1'b0, y}, {1'b0, m});
      run_op(o, x, y, m, fr[DW:0], fr[DW+1], 1'b0, $sformatf("rand%0d_op%0d", n, o));
    end

    @(posedge clk); #1;
    chk("idle_done", (DW+2)'(bus.done), '0);
    chk("idle_busy", (DW+2)'(bus.busy), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
